// File: rtl/tut_nios_mem_test_pkg.sv
// Shared types and constants for the on-chip RAM test master.
package tut_nios_mem_test_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_NADDR = 2'd3
  } mode_e;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  // Right-shifting Galois step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/tut_nios_mem_pattern_gen.sv
// Test pattern source: data for the access being issued now; LFSR steps on advance.
module tut_nios_mem_pattern_gen
  import tut_nios_mem_test_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] data
);

  logic [31:0]       lfsr_q;
  logic [31:0]       seed_eff;
  logic [31:0]       cur;
  logic [ADDR_W-1:0] naddr;

  assign seed_eff = (seed == '0) ? LFSR_SEED : seed[31:0];
  // On load the seed itself is the first word, so the sequence starts without a bubble.
  assign cur      = load ? seed_eff : lfsr_q;
  assign naddr    = ~address;

  always_comb begin
    data = '0;
    case (mode_e'(mode))
      MODE_ADDR:  data = DATA_W'(address);
      MODE_LFSR:  data = DATA_W'(cur);
      MODE_CONST: data = seed;
      default:    data = DATA_W'(naddr);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     lfsr_q <= '0;
    else if (advance) lfsr_q <= lfsr_step(cur);
    else if (load)    lfsr_q <= seed_eff;
  end

endmodule

// File: rtl/tut_nios_mem_test_master.sv
// Fill / read-back / compare master for the single-port on-chip RAM.
module tut_nios_mem_test_master
  import tut_nios_mem_test_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   pattern,
  input  logic [ADDR_W-1:0]   first_addr,
  input  logic [ADDR_W-1:0]   last_addr,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
);

  localparam int CNT_W = ADDR_W + 1;

  state_e            state, state_n;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] pattern_q;
  logic [ADDR_W-1:0] first_q, last_q;

  logic              accept, at_last;
  logic [1:0]        gen_mode;
  logic [DATA_W-1:0] gen_seed, gen_data;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_load, gen_adv;

  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              cs_n, wr_n, rd_n, busy_n, done_n;

  // vld_pipe[0]: read on the bus, vld_pipe[1]: its data is on m_readdata.
  logic [1:0]        vld_pipe;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;
  logic [CNT_W-1:0]  err_count_nxt;

  assign m_byteenable = '1;
  assign accept       = (state == IDLE) && start;
  assign at_last      = (m_address == last_q);

  // In IDLE the generator sees live inputs, since they are latched on the same edge.
  assign gen_mode = (state == IDLE) ? mode : mode_q;
  assign gen_seed = (state == IDLE) ? pattern : pattern_q;
  assign gen_addr = (state == IDLE) ? first_addr :
                    at_last         ? first_q    : m_address + ADDR_W'(1);
  assign gen_load = accept || ((state == WRITE) && at_last);
  assign gen_adv  = gen_load || (((state == WRITE) || (state == READ)) && !at_last);

  tut_nios_mem_pattern_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LFSR_SEED(LFSR_SEED)
  ) u_gen (
    .clk(clk), .reset_n(reset_n), .mode(gen_mode), .seed(gen_seed),
    .address(gen_addr), .load(gen_load), .advance(gen_adv), .data(gen_data)
  );

  always_comb begin
    state_n = state;
    addr_n  = m_address;
    wdata_n = m_writedata;
    cs_n    = 1'b0;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    busy_n  = 1'b1;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n = WRITE;
          addr_n  = gen_addr;
          wdata_n = gen_data;
          cs_n    = 1'b1;
          wr_n    = 1'b1;
          busy_n  = 1'b1;
        end
      end
      WRITE: begin
        cs_n    = 1'b1;
        addr_n  = gen_addr;
        wdata_n = gen_data;
        if (at_last) begin
          state_n = READ;
          rd_n    = 1'b1;
        end else begin
          wr_n = 1'b1;
        end
      end
      READ: begin
        if (at_last) begin
          state_n = DRAIN;
        end else begin
          cs_n    = 1'b1;
          rd_n    = 1'b1;
          addr_n  = gen_addr;
          wdata_n = gen_data;
        end
      end
      DRAIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      m_address    <= '0;
      m_writedata  <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_clken      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      vld_pipe     <= '0;
      cmp_exp      <= '0;
      cmp_addr     <= '0;
      mode_q       <= '0;
      pattern_q    <= '0;
      first_q      <= '0;
      last_q       <= '0;
    end else begin
      state        <= state_n;
      m_address    <= addr_n;
      m_writedata  <= wdata_n;
      m_chipselect <= cs_n;
      m_write      <= wr_n;
      m_clken      <= 1'b1;
      busy         <= busy_n;
      done         <= done_n;
      vld_pipe     <= {vld_pipe[0], rd_n};
      cmp_exp      <= m_writedata;
      cmp_addr     <= m_address;
      if (accept) begin
        mode_q    <= mode;
        pattern_q <= pattern;
        first_q   <= first_addr;
        last_q    <= last_addr;
      end
    end
  end

  assign mismatch      = vld_pipe[1] && (m_readdata != cmp_exp);
  assign err_count_nxt = err_count + CNT_W'(mismatch);

  // The last compare lands on the DRAIN edge, so pass must use the updated count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass           <= 1'b0;
    end else begin
      if (mismatch) begin
        err_count <= err_count_nxt;
        if (err_count == '0) begin
          first_err_addr <= cmp_addr;
          first_err_data <= m_readdata;
        end
      end
      if (state == DRAIN) pass <= (err_count_nxt == '0);
    end
  end

endmodule
